huff_freq_count: RTL and testbench

HUFF_FREQ_COUNT -- requirements
Module: huff_freq_count

---
 rtl/huff_freq_count.sv | 94 +++++++++
 tb/tb_huff_freq_count.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_freq_count.sv
// Per-block symbol histogram for a Huffman tree builder.
// Counts DEPTH symbol lanes, then presents one block to the sorter.
module huff_freq_count #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int SYM_W     = 3,
  parameter int BLOCK_LEN = 255
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic [SYM_W-1:0]       sym_in,
  input  logic                   sym_valid,
  input  logic                   sym_last,
  output logic                   sym_ready,
  output logic [DEPTH*WIDTH-1:0] out_data,
  output logic [DEPTH*WIDTH-1:0] out_probab,
  output logic [WIDTH-1:0]       out_total,
  output logic                   valid,
  input  logic                   ready
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    PRESENT
  } state_t;

  localparam logic [WIDTH-1:0] LP_LEN = WIDTH'(BLOCK_LEN);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_cnt [DEPTH];
  logic [WIDTH-1:0] r_total;
  logic [WIDTH-1:0] w_total_inc;
  logic             w_accept;
  logic             w_final;
  logic             w_hs;

  assign w_accept    = sym_valid && (r_state == COUNT);
  assign w_total_inc = r_total + WIDTH'(1);
  assign w_final     = w_accept &&
                       (sym_last || (w_total_inc == LP_LEN));
  assign w_hs        = (r_state == PRESENT) && ready;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = COUNT;
      COUNT:   if (w_final) w_next = PRESENT;
      PRESENT: if (w_hs) w_next = COUNT;
      default: w_next = IDLE;
    endcase
  end

  // Handshake clears the histogram so the next block starts from zero.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_total <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_hs) begin
      r_total <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_accept) begin
      r_total <= w_total_inc;
      for (int i = 0; i < DEPTH; i++) begin
        if (sym_in == SYM_W'(i)) begin
          r_cnt[i] <= r_cnt[i] + WIDTH'(1);
        end
      end
    end
  end

  assign sym_ready = (r_state == COUNT);
  assign valid     = (r_state == PRESENT);
  assign out_total = r_total;

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    assign out_data[g*WIDTH +: WIDTH]   = WIDTH'(g);
    assign out_probab[g*WIDTH +: WIDTH] = r_cnt[g];
  end

endmodule

// File: tb/tb_huff_freq_count.sv
// Self-checking bench for huff_freq_count: vector table,
// hand sequences and randomized blocks against a histogram model.
module tb_huff_freq_count;

  logic        clock;
  logic        rstn;
  logic [2:0]  sym_in;
  logic        sym_valid;
  logic        sym_last;
  logic        sym_ready;
  logic [63:0] out_data;
  logic [63:0] out_probab;
  logic [7:0]  out_total;
  logic        valid;
  logic        ready;

  int n_tests;
  int n_fail;

  huff_freq_count dut (
    .clock      (clock),
    .rstn       (rstn),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_last   (sym_last),
    .sym_ready  (sym_ready),
    .out_data   (out_data),
    .out_probab (out_probab),
    .out_total  (out_total),
    .valid      (valid),
    .ready      (ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int n;
    int syms[8];
    int exp[8];
    int tot;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int lane_p(input int i);
    return int'(out_probab[i*8 +: 8]);
  endfunction

  function automatic int lane_d(input int i);
    return int'(out_data[i*8 +: 8]);
  endfunction

  task automatic chk_lanes(input string name, input int exp[8]);
    for (int i = 0; i < 8; i++) begin
      chk(name, lane_p(i), exp[i]);
    end
  endtask

  task automatic chk_data(input string name);
    for (int i = 0; i < 8; i++) begin
      chk(name, lane_d(i), i);
    end
  endtask

  task automatic send_block(input int q[$], input bit use_last,
                            input int gap);
    for (int k = 0; k < q.size(); k++) begin
      int guard;
      guard = 0;
      sym_valid = 1'b1;
      sym_in    = 3'(q[k]);
      sym_last  = use_last && (k == q.size() - 1);
      while (!sym_ready && guard < 50) begin
        step();
        guard++;
      end
      if (guard >= 50) begin
        chk("sym_ready_timeout", 0, 1);
        return;
      end
      step();
      sym_valid = 1'b0;
      sym_last  = 1'b0;
      if (k < q.size() - 1) begin
        chk("busy_valid", int'(valid), 0);
        for (int g = 0; g < gap; g++) begin
          step();
          chk("gap_total", int'(out_total), k + 1);
        end
      end
    end
  endtask

  task automatic chk_present(input string name, input int exp[8],
                             input int tot);
    chk({name, "_valid"}, int'(valid), 1);
    chk({name, "_total"}, int'(out_total), tot);
    chk_lanes({name, "_probab"}, exp);
    chk_data({name, "_data"});
  endtask

  task automatic handshake(input int exp[8], input int tot,
                           input int hold);
    int zero[8];
    for (int i = 0; i < 8; i++) zero[i] = 0;
    for (int h = 0; h < hold; h++) begin
      sym_valid = 1'b1;
      sym_in    = 3'($urandom_range(0, 7));
      sym_last  = 1'($urandom_range(0, 1));
      ready     = 1'b0;
      step();
      chk("bp_sym_ready", int'(sym_ready), 0);
      chk("bp_valid", int'(valid), 1);
      chk("bp_total", int'(out_total), tot);
      chk_lanes("bp_probab", exp);
    end
    ready = 1'b1;
    step();
    ready     = 1'b0;
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    chk("hs_valid", int'(valid), 0);
    chk("hs_total", int'(out_total), 0);
    chk("hs_sym_ready", int'(sym_ready), 1);
    chk_lanes("hs_probab", zero);
  endtask

  initial begin
    int q[$];
    int e[8];
    int zero[8];
    n_tests   = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    sym_in    = '0;
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    ready     = 1'b0;
    for (int i = 0; i < 8; i++) zero[i] = 0;

    tbl[0] = '{7, '{0, 1, 1, 3, 7, 7, 7, 0},
               '{1, 2, 0, 1, 0, 0, 0, 3}, 7};
    tbl[1] = '{2, '{2, 2, 0, 0, 0, 0, 0, 0},
               '{0, 0, 2, 0, 0, 0, 0, 0}, 2};
    tbl[2] = '{1, '{4, 0, 0, 0, 0, 0, 0, 0},
               '{0, 0, 0, 0, 1, 0, 0, 0}, 1};
    tbl[3] = '{8, '{0, 1, 2, 3, 4, 5, 6, 7},
               '{1, 1, 1, 1, 1, 1, 1, 1}, 8};
    tbl[4] = '{5, '{7, 0, 7, 0, 7, 0, 0, 0},
               '{2, 0, 0, 0, 0, 0, 0, 3}, 5};

    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_sym_ready", int'(sym_ready), 0);
    chk("rst_total", int'(out_total), 0);
    chk_lanes("rst_probab", zero);
    chk_data("rst_data");
    #11;
    rstn = 1'b1;
    #1;
    chk("idle_sym_ready", int'(sym_ready), 0);
    step();
    chk("count_sym_ready", int'(sym_ready), 1);

    // Table vectors; blocks 1 then 2 run back to back.
    for (int t = 0; t < 5; t++) begin
      q = {};
      for (int k = 0; k < tbl[t].n; k++) q.push_back(tbl[t].syms[k]);
      send_block(q, 1'b1, 0);
      chk_present($sformatf("tbl%0d", t), tbl[t].exp, tbl[t].tot);
      handshake(tbl[t].exp, tbl[t].tot, (t == 0) ? 5 : 0);
    end

    // Full block, final symbol by length only.
    q = {};
    for (int k = 0; k < 255; k++) q.push_back(5);
    e = zero;
    e[5] = 255;
    send_block(q, 1'b0, 0);
    chk_present("full", e, 255);
    handshake(e, 255, 1);

    // Length limit and sym_last together end exactly one block.
    send_block(q, 1'b1, 0);
    chk_present("full_last", e, 255);
    handshake(e, 255, 0);
    step();
    step();
    chk("full_last_single", int'(valid), 0);
    chk("full_last_total", int'(out_total), 0);

    // Idle gaps between accepts.
    q = {6, 6};
    e = zero;
    e[6] = 2;
    send_block(q, 1'b1, 4);
    chk_present("gaps", e, 2);
    handshake(e, 2, 0);

    // Reset in the middle of a block.
    q = {3, 3, 1};
    send_block(q, 1'b0, 0);
    chk("pre_rst_total", int'(out_total), 3);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_total", int'(out_total), 0);
    chk("arst_sym_ready", int'(sym_ready), 0);
    chk("arst_valid", int'(valid), 0);
    chk_lanes("arst_probab", zero);
    #10;
    rstn = 1'b1;
    #1;
    chk("rel_sym_ready", int'(sym_ready), 0);
    step();
    chk("rel_valid", int'(valid), 0);
    chk("rel_sym_ready2", int'(sym_ready), 1);
    q = {1};
    e = zero;
    e[1] = 1;
    send_block(q, 1'b1, 0);
    chk_present("post_rst", e, 1);
    handshake(e, 1, 0);

    // Randomized blocks against the histogram model.
    for (int b = 0; b < 25; b++) begin
      int len;
      int s;
      len = $urandom_range(1, 12);
      q = {};
      e = zero;
      for (int k = 0; k < len; k++) begin
        s = $urandom_range(0, 7);
        q.push_back(s);
        e[s]++;
      end
      ready = 1'($urandom_range(0, 1));
      send_block(q, 1'b1, $urandom_range(0, 2));
      chk_present("rnd", e, len);
      handshake(e, len, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
